// File: rtl/alu_share_arbiter_pkg.sv
// Shared ALU op codes and arbiter FSM state type for alu_share_arbiter.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;
    localparam logic [3:0] OP_NOP  = 4'd15;

    localparam logic [3:0] OP_LAST_LEGAL = 4'd9;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic logic op_is_illegal(input logic [3:0] op);
        return op > OP_LAST_LEGAL;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping.
module rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int PW      = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [PW-1:0]      idx
);

    always_comb begin
        int unsigned c;
        logic        found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            c = (32'(ptr) + k) % NUM_REQ;
            if (en && !found && req[c]) begin
                found    = 1'b1;
                grant[c] = 1'b1;
                idx      = PW'(c);
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU with a single registered response slot.
// Optional macro ALU_ARB_LOCK_EN adds req_lock for back-to-back locked sequences.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int XLEN    = 32,
    parameter int IDW     = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
`ifdef ALU_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]      req_lock,
`endif
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*4-1:0]    req_op,
    input  logic [NUM_REQ*XLEN-1:0] req_a,
    input  logic [NUM_REQ*XLEN-1:0] req_b,
    output logic [3:0]              alu_ctrl,
    output logic [XLEN-1:0]         alu_a,
    output logic [XLEN-1:0]         alu_b,
    input  logic [XLEN-1:0]         alu_result,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [XLEN-1:0]         rsp_data,
    output logic                    rsp_illegal
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t              state, state_nxt;
    logic [PW-1:0]       ptr;
    logic [PW-1:0]       ptr_adv;
    logic [PW-1:0]       gidx;
    logic [NUM_REQ-1:0]  grant;
    logic [NUM_REQ-1:0]  req_eff;
    logic                slot_free;
    logic                accept;
    logic [3:0]          sel_op;

`ifdef ALU_ARB_LOCK_EN
    logic                lock_active;
    logic [NUM_REQ-1:0]  owner_mask;

    // While locked the pointer parks on the owner, so masking others is enough.
    assign owner_mask = {{(NUM_REQ-1){1'b0}}, 1'b1} << ptr;
    assign req_eff    = lock_active ? (req_valid & owner_mask) : req_valid;
`else
    assign req_eff    = req_valid;
`endif

    assign slot_free = (state == IDLE) || ((state == HOLD) && rsp_ready);

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_picker (
        .req   (req_eff),
        .ptr   (ptr),
        .en    (slot_free && rst_n),
        .grant (grant),
        .idx   (gidx)
    );

    assign req_ready = grant;
    assign accept    = |grant;
    assign sel_op    = req_op[32'(gidx)*4 +: 4];
    assign ptr_adv   = (32'(gidx) == NUM_REQ - 1) ? '0 : PW'(gidx + 1'b1);

    always_comb begin
        alu_ctrl = OP_NOP;
        alu_a    = '0;
        alu_b    = '0;
        if (accept) begin
            alu_ctrl = sel_op;
            alu_a    = req_a[32'(gidx)*XLEN +: XLEN];
            alu_b    = req_b[32'(gidx)*XLEN +: XLEN];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = HOLD;
            HOLD: if (rsp_ready && !accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            rsp_data    <= '0;
            rsp_id      <= '0;
            rsp_illegal <= 1'b0;
`ifdef ALU_ARB_LOCK_EN
            lock_active <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (accept) begin
                rsp_data    <= alu_result;
                rsp_id      <= IDW'(gidx);
                rsp_illegal <= op_is_illegal(sel_op);
`ifdef ALU_ARB_LOCK_EN
                lock_active <= req_lock[gidx];
                ptr         <= req_lock[gidx] ? gidx : ptr_adv;
`else
                ptr         <= ptr_adv;
`endif
            end
        end
    end

    assign rsp_valid = (state == HOLD);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter (NUM_REQ=2) with directed and randomized scenarios.
module tb_alu_share_arbiter;

    localparam int N = 2;
    localparam int X = 32;
    localparam int I = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  valid_v;
    logic [N-1:0]  req_ready;
    logic [3:0]    op_r [N];
    logic [X-1:0]  a_r  [N];
    logic [X-1:0]  b_r  [N];
    logic [N*4-1:0] req_op;
    logic [N*X-1:0] req_a;
    logic [N*X-1:0] req_b;
    logic [3:0]    alu_ctrl;
    logic [X-1:0]  alu_a, alu_b, alu_result;
    logic          rsp_valid, rsp_ready, rsp_illegal;
    logic [I-1:0]  rsp_id;
    logic [X-1:0]  rsp_data;
`ifdef ALU_ARB_LOCK_EN
    logic [N-1:0]  lock_v;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign req_op = {op_r[1], op_r[0]};
    assign req_a  = {a_r[1], a_r[0]};
    assign req_b  = {b_r[1], b_r[0]};

    function automatic logic [X-1:0] ref_alu(input logic [3:0] op, input logic [X-1:0] a, input logic [X-1:0] b);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a << b[4:0];
            4'd3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4: return (a < b) ? 32'd1 : 32'd0;
            4'd5: return a ^ b;
            4'd6: return a >> b[4:0];
            4'd7: return $unsigned($signed(a) >>> b[4:0]);
            4'd8: return a | b;
            4'd9: return a & b;
            default: return '0;
        endcase
    endfunction

    assign alu_result = ref_alu(alu_ctrl, alu_a, alu_b);

    alu_share_arbiter #(.NUM_REQ(N), .XLEN(X), .IDW(I)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (valid_v),
`ifdef ALU_ARB_LOCK_EN
        .req_lock    (lock_v),
`endif
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .alu_ctrl    (alu_ctrl),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .rsp_illegal (rsp_illegal)
    );

    task automatic set_req(input int i, input logic v, input logic [3:0] op, input logic [X-1:0] a, input logic [X-1:0] b);
        valid_v[i] = v;
        op_r[i]    = op;
        a_r[i]     = a;
        b_r[i]     = b;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        valid_v   = '0;
        rsp_ready = 1'b0;
`ifdef ALU_ARB_LOCK_EN
        lock_v    = '0;
`endif
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 4'd15, '0, '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0b want 0", rsp_valid); end
        n_cmp++; if (rsp_data !== '0) begin n_bad++; $display("FAIL reset_data got %h want 0", rsp_data); end
        n_cmp++; if (rsp_id !== '0) begin n_bad++; $display("FAIL reset_id got %0d want 0", rsp_id); end
        n_cmp++; if (rsp_illegal !== 1'b0) begin n_bad++; $display("FAIL reset_illegal got %0b want 0", rsp_illegal); end
        #1;
        n_cmp++; if (alu_ctrl !== 4'd15 || alu_a !== '0 || alu_b !== '0) begin
            n_bad++; $display("FAIL idle_alu ctrl %0d a %h b %h want 15/0/0", alu_ctrl, alu_a, alu_b);
        end
        rst_n = 1'b0;
        set_req(0, 1'b1, 4'd0, 32'd1, 32'd1);
        set_req(1, 1'b1, 4'd0, 32'd1, 32'd1);
        #1;
        n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL ready_in_reset got %b want 00", req_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        do_reset();
        rsp_ready = 1'b1;
        set_req(0, 1'b1, 4'd0, 32'd5, 32'd7);
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL single_ready got %b want 01", req_ready); end
        n_cmp++; if (alu_ctrl !== 4'd0 || alu_a !== 32'd5 || alu_b !== 32'd7) begin
            n_bad++; $display("FAIL single_alu ctrl %0d a %h b %h want 0/5/7", alu_ctrl, alu_a, alu_b);
        end
        @(posedge clk); #1;
        valid_v[0] = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 3'd0 || rsp_data !== 32'd12 || rsp_illegal !== 1'b0) begin
            n_bad++; $display("FAIL single_rsp v %0b id %0d data %h ill %0b want 1/0/c/0", rsp_valid, rsp_id, rsp_data, rsp_illegal);
        end
        @(posedge clk); #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL single_drain got %0b want 0", rsp_valid); end
    endtask

    task automatic test_contention();
        do_reset();
        rsp_ready = 1'b1;
        set_req(0, 1'b1, 4'd1, 32'd9, 32'd4);
        set_req(1, 1'b1, 4'd5, 32'hF0, 32'h0F);
        for (int k = 0; k < 6; k++) begin
            #1;
            n_cmp++; if (req_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                n_bad++; $display("FAIL contention_grant cycle %0d got %b", k, req_ready);
            end
            @(posedge clk); #1;
            n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== ((k % 2 == 0) ? 32'd5 : 32'hFF) || rsp_id !== I'(k % 2)) begin
                n_bad++; $display("FAIL contention_rsp cycle %0d v %0b data %h id %0d", k, rsp_valid, rsp_data, rsp_id);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        rsp_ready = 1'b1;
        set_req(1, 1'b1, 4'd3, 32'hFFFF_FFFF, 32'd1);
        #1;
        n_cmp++; if (req_ready !== 2'b10) begin n_bad++; $display("FAIL bp_accept got %b want 10", req_ready); end
        @(posedge clk); #1;
        valid_v[1] = 1'b0;
        set_req(0, 1'b1, 4'd0, 32'd2, 32'd3);
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (req_ready !== 2'b00 || rsp_valid !== 1'b1 || rsp_data !== 32'd1 || rsp_id !== 3'd1) begin
                n_bad++; $display("FAIL bp_hold cycle %0d ready %b v %0b data %h id %0d", k, req_ready, rsp_valid, rsp_data, rsp_id);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL bp_release got %b want 01", req_ready); end
        @(posedge clk); #1;
        valid_v[0] = 1'b0;
        n_cmp++; if (rsp_data !== 32'd5 || rsp_id !== 3'd0 || rsp_valid !== 1'b1) begin
            n_bad++; $display("FAIL bp_refill data %h id %0d v %0b want 5/0/1", rsp_data, rsp_id, rsp_valid);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        rsp_ready = 1'b1;
        set_req(0, 1'b1, 4'd12, 32'd3, 32'd3);
        @(posedge clk); #1;
        n_cmp++; if (rsp_illegal !== 1'b1 || rsp_data !== '0 || rsp_valid !== 1'b1) begin
            n_bad++; $display("FAIL illegal_rsp ill %0b data %h v %0b want 1/0/1", rsp_illegal, rsp_data, rsp_valid);
        end
        set_req(0, 1'b1, 4'd0, 32'd1, 32'd1);
        set_req(1, 1'b1, 4'd0, 32'd1, 32'd2);
        #1;
        n_cmp++; if (req_ready !== 2'b10) begin n_bad++; $display("FAIL illegal_ptr got %b want 10", req_ready); end
        @(posedge clk); #1;
        n_cmp++; if (rsp_illegal !== 1'b0 || rsp_data !== 32'd3) begin
            n_bad++; $display("FAIL illegal_clear ill %0b data %h want 0/3", rsp_illegal, rsp_data);
        end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        rsp_ready = 1'b1;
        set_req(0, 1'b1, 4'd8, 32'hA0, 32'h0A);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        set_req(1, 1'b1, 4'd0, 32'd1, 32'd1);
        n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL rmh_hold got %0b want 1", rsp_valid); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL rmh_ready got %b want 00", req_ready); end
        @(posedge clk); #1;
        n_cmp++; if (rsp_valid !== 1'b0 || rsp_data !== '0) begin
            n_bad++; $display("FAIL rmh_cleared v %0b data %h want 0/0", rsp_valid, rsp_data);
        end
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL rmh_first_grant got %b want 01", req_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int          m_ptr, m_id, g;
        bit          m_hold, m_ill;
        logic [X-1:0] m_data;
        logic [N-1:0] exp_ready;
        do_reset();
        m_ptr = 0; m_hold = 0; m_id = 0; m_ill = 0; m_data = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!valid_v[i])
                    set_req(i, ($urandom_range(0, 2) != 0), 4'($urandom_range(0, 15)), $urandom, $urandom);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            g = -1;
            if (!m_hold || rsp_ready)
                for (int k = 0; k < N; k++)
                    if (g < 0 && valid_v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            exp_ready = (g >= 0) ? N'(1 << g) : '0;
            #1;
            n_cmp++; if (req_ready !== exp_ready) begin
                n_bad++; $display("FAIL rand_ready cycle %0d got %b want %b", cyc, req_ready, exp_ready);
            end
            if (g >= 0) begin
                m_data = ref_alu(op_r[g], a_r[g], b_r[g]);
                m_ill  = (op_r[g] > 4'd9);
                m_id   = g;
                m_ptr  = (g + 1) % N;
                m_hold = 1;
            end else if (m_hold && rsp_ready) begin
                m_hold = 0;
            end
            @(posedge clk); #1;
            if (g >= 0) valid_v[g] = 1'b0;
            n_cmp++; if (rsp_valid !== m_hold) begin
                n_bad++; $display("FAIL rand_valid cycle %0d got %0b want %0b", cyc, rsp_valid, m_hold);
            end
            if (m_hold) begin
                n_cmp++; if (rsp_data !== m_data || rsp_id !== I'(m_id) || rsp_illegal !== m_ill) begin
                    n_bad++; $display("FAIL rand_rsp cycle %0d data %h id %0d ill %0b want %h/%0d/%0b",
                                      cyc, rsp_data, rsp_id, rsp_illegal, m_data, m_id, m_ill);
                end
            end
        end
    endtask

`ifdef ALU_ARB_LOCK_EN
    task automatic test_lock();
        logic [N-1:0] want [4];
        logic         lk   [3];
        want[0] = 2'b10; want[1] = 2'b10; want[2] = 2'b10; want[3] = 2'b01;
        lk[0] = 1'b1; lk[1] = 1'b1; lk[2] = 1'b0;
        do_reset();
        rsp_ready = 1'b1;
        set_req(0, 1'b1, 4'd0, 32'd1, 32'd1);
        @(posedge clk); #1;
        set_req(1, 1'b1, 4'd3, 32'd1, 32'd2);
        for (int k = 0; k < 4; k++) begin
            lock_v[1] = (k < 3) ? lk[k] : 1'b0;
            #1;
            n_cmp++; if (req_ready !== want[k]) begin
                n_bad++; $display("FAIL lock_grant step %0d got %b want %b", k, req_ready, want[k]);
            end
            @(posedge clk); #1;
        end
        valid_v = '0;
        lock_v  = '0;
        @(posedge clk); #1;
        lock_v[1] = 1'b1;
        set_req(1, 1'b1, 4'd0, 32'd1, 32'd1);
        @(posedge clk); #1;
        valid_v[1] = 1'b0;
        set_req(0, 1'b1, 4'd0, 32'd1, 32'd1);
        #1;
        n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL lock_owner_idle got %b want 00", req_ready); end
        @(posedge clk); #1;
        lock_v = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_illegal();
        test_reset_mid_hold();
`ifdef ALU_ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU between NUM_REQ requesters, for example the execute stage and the branch/address-generation unit.
- Uses per-requester valid/ready request channels and round-robin grant.
- Drives the ALU operand and control inputs from the granted request, then captures the ALU result into a single registered response slot.
- Sits between the issue logic and the ALU instance in the core.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- XLEN, 32, operand/result width.
- IDW, 3, width of the response requester-id field; must satisfy 2^IDW >= NUM_REQ.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_op  in  NUM_REQ*4  per-requester ALU control code (ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, NOP=15); slice i = bits [4i+3:4i].
- req_a  in  NUM_REQ*XLEN  operand A, flattened, slice i.
- req_b  in  NUM_REQ*XLEN  operand B, flattened, slice i.
- alu_ctrl  out  4  to ALU control input.
- alu_a  out  XLEN  to ALU operand A.
- alu_b  out  XLEN  to ALU operand B.
- alu_result  in  XLEN  combinational ALU result.
- rsp_valid  out  1  response slot full.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_data  out  XLEN  registered ALU result.
- rsp_illegal  out  1  op code was 10..15 (undefined or NOP).

Behaviour:
- Reset (rst_n low at a clk edge):
  - rsp_valid=0, rsp_data=0, rsp_id=0, rsp_illegal=0.
  - Round-robin pointer=0, state=IDLE.
  - While rst_n is low, req_ready=0.
  - Reset asserted mid-operation discards any held response with no notification.
- FSM states:
  - IDLE: response slot empty.
  - HOLD: slot full, waiting for rsp_ready.
- slot_free = (state==IDLE) or (state==HOLD and rsp_ready).
  - Same-cycle drain-and-refill is allowed, giving 1 result per cycle sustained.
- Grant, combinational:
  - If slot_free, grant goes to the first asserted req_valid scanning from the pointer upward, with wrap-around modulo NUM_REQ.
  - req_ready is asserted only on the granted index; all zero otherwise.
- ALU drive:
  - When a grant exists, alu_ctrl/alu_a/alu_b come from the granted slice.
  - Otherwise alu_ctrl=NOP (15) and alu_a=alu_b=0, so there is no spurious toggling.
- Accept (req_valid[i] and req_ready[i]) at edge N:
  - rsp_data<=alu_result, rsp_id<=i, rsp_illegal<=(op>9).
  - rsp_valid=1 from cycle N+1 (latency 1); state->HOLD.
  - Pointer <= (i+1) mod NUM_REQ.
- Illegal ops are accepted normally; rsp_data takes whatever the ALU returns for the NOP code (0) and rsp_illegal=1.
- HOLD with rsp_ready=1 and no new grant -> IDLE, rsp_valid=0.
  - rsp_data/rsp_id hold their last values; they are don't-care when rsp_valid=0.
- HOLD with rsp_ready=0:
  - All req_ready=0.
  - rsp_* outputs are stable.
  - Pointer is unchanged.
- Requesters must hold req_op/req_a/req_b stable while req_valid is high and not yet accepted. The arbiter does not register requests; violating this is a protocol error.
- Starvation-free: with all requesters continuously valid and rsp_ready=1, each requester is granted once every NUM_REQ cycles.

Optional Feature:
- ALU_ARB_LOCK_EN defined:
  - Adds input req_lock[NUM_REQ].
  - If the requester accepted at edge N had req_lock high, the pointer stays at that requester instead of advancing.
  - For the following cycles, only that requester may be granted until it is accepted with req_lock=0. This supports back-to-back dependent sequences, e.g. SLT then SUB.
  - While the lock is held and the owner is not valid, no grant is issued.
  - Reset clears the lock.
- Undefined: no req_lock port; pure round-robin as above.

Decomposition:
- Package alu_pkg:
  - 4-bit ALU op localparams ADD..AND, NOP.
  - OP_LAST_LEGAL=9.
  - FSM state encoding IDLE=0, HOLD=1.
- Sub-module rr_picker (NUM_REQ):
  - Combinational.
  - Inputs: request vector, pointer, enable.
  - Outputs: one-hot grant and binary index.
- Top level holds the FSM, pointer, response registers and operand muxing.

Test Plan:
- Single request: req_valid=01, op=ADD, a=5, b=7, rsp_ready=1.
  - Expect req_ready=01 the same cycle.
  - Next cycle: rsp_valid=1, rsp_id=0, rsp_data=12, rsp_illegal=0.
- Contention, NUM_REQ=2: both valid continuously, rsp_ready=1, r0 op SUB (9,4), r1 op XOR (F0,0F).
  - Expect grants alternating 0,1,0,1 from reset.
  - rsp_data alternates 5, FF.
  - One response per cycle.
- Backpressure: accept r1 (SLT, -1, 1), then hold rsp_ready=0 for 3 cycles.
  - rsp_valid=1, rsp_data=1 and rsp_id=1 stay stable.
  - req_ready=00 throughout.
  - On release, r0 is granted in the same cycle.
- Illegal op: r0 op=12, a=3, b=3.
  - Expect rsp_illegal=1 and rsp_data=0.
  - The pointer still advances to 1.
- Reset mid-HOLD: rsp_valid=1, drive rst_n=0 for one edge.
  - Expect rsp_valid=0, req_ready=00, pointer=0.
  - First post-reset grant goes to r0 when both requesters are valid.
- ALU_ARB_LOCK_EN: r1 issues 3 ops with req_lock=1,1,0 while r0 is valid.
  - Expect grants 1,1,1, then 0.
